// File: rtl/tdc_pkg.sv
// Shared types and default sizes for the TDC stimulus and capture blocks.
package tdc_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, FIRE, HOLD} state_e;

  localparam int DELAY_W_DEF     = 8;
  localparam int WIDTH_W_DEF     = 4;
  localparam int REP_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int HOLDOFF_DEF     = 4;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an async level, followed by a registered rising-edge pulse.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/tdc_pulse_pair_gen.sv
// Programmable start/stop pulse-pair generator driving the TDC inputs for self-test.
module tdc_pulse_pair_gen
  import tdc_pkg::*;
#(
  parameter int DELAY_W     = DELAY_W_DEF,
  parameter int WIDTH_W     = WIDTH_W_DEF,
  parameter int REP_W       = REP_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int HOLDOFF     = HOLDOFF_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [REP_W-1:0]   cfg_rep,
  input  logic               trig,
  input  logic               abort,
  output logic               start_o,
  output logic               stop_o,
  output logic               busy,
  output logic               done,
  output logic [REP_W-1:0]   shots_left
);
  // One extra bit so D+W-1 never wraps; also reused as the holdoff counter.
  localparam int TW = DELAY_W + 1;

  state_e             state_q, state_d;
  logic [TW-1:0]      t_q, t_d;
  logic [DELAY_W-1:0] d_q, d_d;
  logic [WIDTH_W-1:0] w_q, w_d;
  logic [REP_W-1:0]   left_q, left_d;
  logic               start_q, start_d, stop_q, stop_d, done_q, done_d;
  logic               trig_rise, kill, latch, fire_last, hold_last;

  sync_edge #(.STAGES(SYNC_STAGES)) u_trig_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (trig),
    .rise_o  (trig_rise)
  );

  assign kill      = abort | ~ena;
  assign latch     = (state_q == IDLE) & cfg_valid & ~kill;
  assign fire_last = (state_q == FIRE) && (t_q == TW'(d_q) + TW'(w_q) - TW'(1));
  assign hold_last = (state_q == HOLD) && (t_q == TW'(HOLDOFF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (cfg_valid) state_d = ARMED;
        ARMED:   if (trig_rise) state_d = FIRE;
        FIRE:    if (fire_last) state_d = HOLD;
        HOLD:    if (hold_last) state_d = (left_q != '0) ? ARMED : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state/count so the flops line up with t.
  always_comb begin
    start_d = 1'b0;
    stop_d  = 1'b0;
    done_d  = hold_last & ~kill & (left_q == '0);
    if (state_d == FIRE) begin
      start_d = t_d < TW'(w_q);
      stop_d  = (t_d >= TW'(d_q)) && (t_d < TW'(d_q) + TW'(w_q));
    end
  end

  always_comb begin
    t_d    = '0;
    d_d    = d_q;
    w_d    = w_q;
    left_d = left_q;
    if ((state_d == state_q) && ((state_q == FIRE) || (state_q == HOLD)))
      t_d = t_q + TW'(1);
    if (latch) begin
      d_d    = cfg_delay;
      w_d    = (cfg_width == '0) ? WIDTH_W'(1) : cfg_width;
      left_d = (cfg_rep == '0) ? REP_W'(1) : cfg_rep;
    end
    if (fire_last) left_d = left_q - REP_W'(1);
    if (kill)      left_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q     <= '0;
      d_q     <= '0;
      w_q     <= '0;
      left_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      t_q     <= t_d;
      d_q     <= d_d;
      w_q     <= w_d;
      left_q  <= left_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  assign cfg_ready  = (state_q == IDLE);
  assign shots_left = left_q;
endmodule
